// File: rtl/mips_pkg.sv
// Shared encodings for the HI/LO multiply/divide datapath.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle, fixed 33-edge latency
// from start to the done pulse, plus MTHI/MTLO moves while idle.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        return (is_signed && v[DATA_W-1]) ? -v : v;
    endfunction

    logic [1:0]          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   orig_a_q, orig_a_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;

    logic                is_signed_op;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_trial;
    logic [2*DATA_W-1:0] fin_prod;
    logic [DATA_W-1:0]   fin_quo, fin_rem;

    assign is_signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign a_mag        = magnitude(op_a, is_signed_op);
    assign b_mag        = magnitude(op_b, is_signed_op);

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign div_trial = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, b_q};

    assign fin_prod = neg_res_q ? -acc_q : acc_q;
    assign fin_quo  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign fin_rem  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        orig_a_d  = orig_a_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (mthi) hi_d = wr_data;
                if (mtlo) lo_d = wr_data;
                if (start) begin
                    op_d      = op;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    orig_a_d  = op_a;
                    neg_res_d = is_signed_op && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                    neg_rem_d = is_signed_op && op_a[DATA_W-1];
                    acc_d     = op[1] ? {{DATA_W{1'b0}}, a_mag} : {{DATA_W{1'b0}}, b_mag};
                    cnt_d     = '0;
                    state_d   = ST_CALC;
                end
            end

            ST_CALC: begin
                if (op_q[1]) begin
                    if (!div_trial[DATA_W])
                        acc_d = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*DATA_W-2:DATA_W-1], acc_q[DATA_W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1))
                    state_d = ST_FINISH;
            end

            ST_FINISH: begin
                if (op_q[1]) begin
                    // A zero divisor still runs the full iteration count; only the result is overridden.
                    if (b_q == '0) begin
                        hi_d  = orig_a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d  = fin_rem;
                        lo_d  = fin_quo;
                        dbz_d = 1'b0;
                    end
                end else begin
                    {hi_d, lo_d} = fin_prod;
                    dbz_d        = 1'b0;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= MD_MULT;
            a_q       <= '0;
            b_q       <= '0;
            orig_a_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            orig_a_q  <= orig_a_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed plan vectors, HI/LO moves,
// randomized operations against an arithmetic reference, and reset/abort robustness.
module tb_mult_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int   vectors = 0;
    int   miscompares = 0;
    logic prev_dbz = 1'b0;

    mult_div_unit #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Architectural result computed with plain 64-bit arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] rh,
                                      output logic [W-1:0] rl, output logic rdbz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rdbz = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            MD_MULT: begin
                p = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            MD_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    rh = a;
                    rl = 32'hFFFF_FFFF;
                    rdbz = 1'b1;
                end else if (o == MD_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    rl = q[31:0];
                    rh = r[31:0];
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Issue one operation at the current negedge and check the whole transaction.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic mvh, input logic mvl,
                          input logic [W-1:0] wd);
        logic [W-1:0] eh, el;
        logic         edbz, got;
        int           k, busy_cnt;
        ref_model(o, a, b, eh, el, edbz);
        op = o; op_a = a; op_b = b; start = 1'b1;
        mthi = mvh; mtlo = mvl; wr_data = wd;
        @(posedge clk); @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); op = 2'($urandom);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s done_pulse: got %b, expected 0 after start", name, done);
        end
        if (mvh) begin
            vectors++;
            if (hi !== wd) begin
                miscompares++;
                $display("[TB] FAIL %s mthi_with_start: got %h, expected %h", name, hi, wd);
            end
        end
        if (mvl) begin
            vectors++;
            if (lo !== wd) begin
                miscompares++;
                $display("[TB] FAIL %s mtlo_with_start: got %h, expected %h", name, lo, wd);
            end
        end
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        k = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (k == 5) begin
                vectors++;
                if (div_by_zero !== prev_dbz) begin
                    miscompares++;
                    $display("[TB] FAIL %s dbz_hold: got %b, expected %b", name, div_by_zero, prev_dbz);
                end
            end
            if (done === 1'b1) got = 1'b1;
            else if (busy === 1'b1) busy_cnt++;
        end
        vectors++;
        if (!got || k != 33) begin
            miscompares++;
            $display("[TB] FAIL %s latency: got %0d edges (done seen=%b), expected 33", name, k, got);
        end
        vectors++;
        if (busy_cnt != 33) begin
            miscompares++;
            $display("[TB] FAIL %s busy_cycles: got %0d, expected 33", name, busy_cnt);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s busy_at_done: got %b, expected 0", name, busy);
        end
        vectors++;
        if (hi !== eh) begin
            miscompares++;
            $display("[TB] FAIL %s hi: got %h, expected %h", name, hi, eh);
        end
        vectors++;
        if (lo !== el) begin
            miscompares++;
            $display("[TB] FAIL %s lo: got %h, expected %h", name, lo, el);
        end
        vectors++;
        if (div_by_zero !== edbz) begin
            miscompares++;
            $display("[TB] FAIL %s div_by_zero: got %b, expected %b", name, div_by_zero, edbz);
        end
        prev_dbz = edbz;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, div_by_zero, hi, lo} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all 0",
                     busy, done, div_by_zero, hi, lo);
        end
        rst_n = 1'b1;
        prev_dbz = 1'b0;
    endtask

    // Plan vectors, issued back to back so each start lands in the done cycle.
    task automatic test_directed();
        run_op("mult_5x10",     MD_MULT,  32'd5,          32'd10,         1'b0, 1'b0, '0);
        run_op("mult_neg3x7",   MD_MULT,  32'hFFFF_FFFD,  32'd7,          1'b0, 1'b0, '0);
        run_op("multu_max",     MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, '0);
        run_op("div_neg7_2",    MD_DIV,   32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0, '0);
        run_op("div_min_neg1",  MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, '0);
        run_op("divu_20_0",     MD_DIVU,  32'd20,         32'd0,          1'b0, 1'b0, '0);
        run_op("div_7_neg0",    MD_DIV,   32'hFFFF_FFF9,  32'd0,          1'b0, 1'b0, '0);
        run_op("divu_100_7",    MD_DIVU,  32'd100,        32'd7,          1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_move_start", MD_MULT, 32'd3, 32'd4, 1'b1, 1'b1, 32'h5555_AAAA);
        run_op("b2b_mult_neg",   MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0);
    endtask

    task automatic test_random();
        logic [1:0]   o;
        logic [W-1:0] a, b;
        for (int i = 0; i < 50; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = ($urandom_range(0, 7) == 0) ? '0 : pick_operand();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_op($sformatf("rand_%0d", i), o, a, b, 1'b0, 1'b0, '0);
        end
    endtask

    // Moves in IDLE, ignored start/moves mid-operation, and asynchronous abort.
    task automatic test_robustness();
        int   k;
        logic saw_done;
        @(negedge clk);
        mthi = 1'b1; wr_data = 32'hAAAA_0000;
        @(negedge clk);
        mthi = 1'b0;
        vectors++;
        if (hi !== 32'hAAAA_0000) begin
            miscompares++;
            $display("[TB] FAIL mthi_idle: got %h, expected aaaa0000", hi);
        end

        op = MD_MULT; op_a = 32'd5; op_b = 32'd10; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        start = 1'b1; op = MD_DIVU; op_a = 32'd99; op_b = 32'd3;
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        k = 10;
        saw_done = 1'b0;
        while (!saw_done && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (done === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (!saw_done || k != 33) begin
            miscompares++;
            $display("[TB] FAIL robust_latency: got %0d edges (done seen=%b), expected 33", k, saw_done);
        end
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd50) begin
            miscompares++;
            $display("[TB] FAIL robust_result: got hi=%h lo=%h, expected hi=0 lo=32", hi, lo);
        end

        op = MD_MULT; op_a = 32'd5; op_b = 32'd10; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, div_by_zero, hi, lo} !== '0) begin
            miscompares++;
            $display("[TB] FAIL abort_state: got busy=%b done=%b hi=%h lo=%h, expected all 0",
                     busy, done, hi, lo);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("[TB] FAIL abort_quiet: got activity during reset, expected none");
        end
        rst_n = 1'b1;
        prev_dbz = 1'b0;
        run_op("post_reset_divu", MD_DIVU, 32'd20, 32'd5, 1'b0, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_directed();
        test_back_to_back();
        test_random();
        test_robustness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits directly downstream of the register file and consumes its two read ports: rs feeds op_a, rt feeds op_b.
- Holds the architectural HI/LO registers and supports MTHI/MTLO writes.
- The hi/lo outputs feed the MFHI/MFLO write-back path into the register file.

Parameters:
- DATA_W, 32, operand and HI/LO width. The iteration count equals DATA_W.

Ports:
- clk  input  1  rising-edge clock, the single clock of the block.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request, sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  input  DATA_W  rs value (multiplicand / dividend).
- op_b  input  DATA_W  rt value (multiplier / divisor).
- mthi  input  1  write wr_data to HI.
- mtlo  input  1  write wr_data to LO.
- wr_data  input  DATA_W  MTHI/MTLO data (rs value).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO now hold a new result.
- div_by_zero  output  1  qualifies done: last DIV/DIVU had op_b == 0.
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.

Behaviour:
- Reset (async assert, sync release): state IDLE; hi, lo, busy, done, div_by_zero = 0; internal accumulators cleared.
- FSM states: IDLE, CALC, FINISH.
- IDLE + start at edge E0:
  - Latch op.
  - Signed ops: latch |op_a| and |op_b|, plus result sign and remainder sign.
  - Unsigned ops: latch raw operands.
  - Clear the iteration counter; busy = 1; go to CALC.
- CALC, edges E1..E32, one bit per cycle:
  - Multiply: shift-add into a 2*DATA_W product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After the 32nd iteration, go to FINISH.
- FINISH, edge E33:
  - Apply sign correction.
  - Write hi/lo; busy = 0; done = 1 for exactly one cycle; return to IDLE.
  - Fixed latency: done is visible in the cycle after E33, i.e. 33 edges after start is sampled. hi/lo change on the same edge.
- MULT/MULTU: {hi, lo} = the 64-bit product (signed or unsigned).
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / -1 gives lo = 0x80000000, hi = 0. No trap.
- DIVU: unsigned quotient and remainder.
- Divide by zero (op_b == 0, DIV or DIVU):
  - Uniform 33-cycle latency.
  - hi = original op_a; lo = 0xFFFFFFFF; div_by_zero = 1 with done.
- div_by_zero holds until the next done and is cleared by any non-zero-divisor completion.
- start while busy: ignored, with no effect on the in-flight operation.
- mthi/mtlo while busy: ignored.
- mthi/mtlo in IDLE: take effect at the next edge; both may be asserted together.
  - If start is asserted in the same cycle, the move and the start are both accepted. The later FINISH overwrites HI/LO.
- Operands are sampled only at the start edge. Later changes to op_a/op_b are ignored.
- rst_n assertion mid-operation: immediate abort to the reset values, with no done pulse. A start in the first cycle after release is accepted normally.

Decomposition:
- Shared package mips_pkg holds:
  - the MD_OP encoding constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the FSM state encoding;
  - DATA_W default 32.
- No sub-module is required. The iterative core stays in this single module. The sign-magnitude conversion is an internal function.

Test Plan:
- MULT op_a=5, op_b=10 -> done exactly 33 cycles after start; hi=0x00000000, lo=0x00000032; busy high for those 33 cycles.
- MULT op_a=-3 (0xFFFFFFFD), op_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV op_a=-7, op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV op_a=0x80000000, op_b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- DIVU op_a=20, op_b=0 -> done after 33 cycles; div_by_zero=1; hi=0x00000014; lo=0xFFFFFFFF.
- Robustness sequence:
  - mthi 0xAAAA0000 in IDLE, then start MULT 5*10.
  - Second start and mtlo at cycle 10 -> both ignored; final hi=0, lo=50.
  - Repeat, and drop rst_n at cycle 10 -> hi=lo=0, busy=0, no done.
  - Fresh start 20/5 DIVU -> lo=4, hi=0.
